access_control_mu: RTL and testbench
====================================

Name: access_control_mu

Overview:
- Parametrised multi-user successor to the single-password access controller.
- Holds NUM_USERS enrolled passwords of DATA_WIDTH bits and authenticates load strobes against the selected user slot.
- Tracks a failed-attempt count per user; after MAX_TRIES consecutive failures it applies a timed lockout.
- Sits between the keypad/data-entry front end and the door/unlock logic, and reports per-user grant state plus a 3-bit status frame.

Parameters:
- DATA_WIDTH, 16: password/data width in bits.
- NUM_USERS, 4: number of user slots (>=2); USER_W = clog2(NUM_USERS).
- MAX_TRIES, 3: consecutive failed authentications on one slot that trigger lockout (1..7).
- LOCK_CYCLES, 64: lockout duration in clk cycles; LOCK_W = clog2(LOCK_CYCLES+1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- _Request  in  2  command: 00 authenticate, 01 enroll/set, 10 clear slot, 11 logout.
- _User  in  USER_W  target slot index.
- _Data_In  in  DATA_WIDTH  password value.
- _Data_In_Load  in  1  load strobe, level; may be held for several cycles.
- _Status_Frame  out  3  result code (see Behaviour).
- _Granted  out  NUM_USERS  per-slot session-active flags.
- _Lock_Remaining  out  LOCK_W  lockout cycles remaining; 0 when unlocked.

Behaviour:
- Reset (rst=0 at posedge): all slots unenrolled, passwords=0, fail counters=0, _Granted=0, _Status_Frame=000, _Lock_Remaining=0, load_q=0, FSM=IDLE. Reset mid-lockout or mid-session aborts it fully.
- Command acceptance: load_q registers _Data_In_Load every cycle. A command is accepted on a posedge where _Data_In_Load=1 and load_q=0 (rising edge). Holding the strobe issues exactly one command. _Request, _User and _Data_In are sampled on that same edge.
- Latency: outputs update on the accepting edge (registered), visible one cycle after the inputs are presented. Status holds until the next accepted command or a lock event.
- Status codes: 000 idle; 001 stored; 010 granted; 011 denied; 100 locked; 101 not enrolled; 110 cleared; 111 logged out.
- FSM states: IDLE (accepting) and LOCKED. IDLE goes to LOCKED on a failure that reaches MAX_TRIES. LOCKED returns to IDLE when the timer reaches 0.
- Authenticate (00):
  - Slot unenrolled: 101, no counter change.
  - Match: 010, set _Granted[_User], clear that slot's fail counter.
  - Mismatch: 011, clear _Granted[_User], increment the fail counter (saturating at MAX_TRIES).
  - If the counter reaches MAX_TRIES: status 100, enter LOCKED, load _Lock_Remaining=LOCK_CYCLES.
- Enroll (01):
  - Allowed if the slot is unenrolled or _Granted[_User]=1. Stores _Data_In, marks the slot enrolled, clears its fail counter, status 001.
  - Otherwise status 011; the fail counter is not incremented.
- Clear (10): requires _Granted[_User]=1. Unenrolls the slot, zeroes its password, clears _Granted and fail count, status 110. Otherwise 011.
- Logout (11): clears _Granted[_User], status 111, unconditional.
- LOCKED state:
  - All rising edges are ignored, including logout. Status stays 100.
  - _Lock_Remaining decrements by 1 per cycle. On the cycle it reaches 0, FSM returns to IDLE, status becomes 000, and the locking slot's fail counter clears.
  - Other slots' counters and _Granted flags are preserved; lockout is global.
  - A strobe held high across lock exit does not fire, because there is no new rising edge.
- Password 0 is a legal value. Comparison is a full DATA_WIDTH equality check.
- _User >= NUM_USERS (non-power-of-2 configurations) is treated as an unenrolled slot: status 101 for every command, no state change.

Test Plan:
- Reset then enroll user 0 with 16'h1476, strobe held 2 cycles → status 001 exactly once, one accepted command, _Granted=0000.
- Authenticate user 0 with 16'h1476 → status 010, _Granted=0001. Then enroll user 0 with 16'h2456 → 001. Authenticate with 16'h1476 → 011, _Granted=0000, fail count 1.
- Authenticate user 1 (unenrolled) with 16'hAAAA → status 101, no lock. Enroll user 1 with 16'hAAAA without a session → 001. Re-enroll user 1 with 16'h0000 without a session → 011.
- Three wrong authentications on user 2 (after enrolling 16'h1234) → 011, 011, then 100. _Lock_Remaining=64 decrementing to 0. Strobes during the lock are ignored. Status 000 after 64 cycles. The next correct auth → 010.
- User 3 granted before user 2 locks → _Granted[3] stays 1 through the lockout. Logout user 3 after unlock → 111, _Granted=0000.
- Assert rst=0 at _Lock_Remaining=30 → next cycle all outputs are 0, FSM IDLE, all slots unenrolled; auth user 0 with 16'h1476 → 101.

Source files
------------

// File: rtl/access_control_mu_if.sv
// Bus between the keypad/data-entry front end and the multi-user access
// controller. The front end (master) drives a command and raises the level
// strobe _Data_In_Load; the controller (slave) returns status, per-slot grant
// flags and the remaining lockout time.
interface access_control_mu_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_USERS   = 4,
   parameter int LOCK_CYCLES = 64
);
   localparam int USER_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
   localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

   logic [1:0]            _Request;
   logic [USER_W-1:0]     _User;
   logic [DATA_WIDTH-1:0] _Data_In;
   logic                  _Data_In_Load;
   logic [2:0]            _Status_Frame;
   logic [NUM_USERS-1:0]  _Granted;
   logic [LOCK_W-1:0]     _Lock_Remaining;

   modport master (
      output _Request, _User, _Data_In, _Data_In_Load,
      input  _Status_Frame, _Granted, _Lock_Remaining
   );

   modport slave (
      input  _Request, _User, _Data_In, _Data_In_Load,
      output _Status_Frame, _Granted, _Lock_Remaining
   );
endinterface

// File: rtl/access_control_mu.sv
// Multi-user access controller: enrolled passwords per slot, per-slot
// failed-attempt counters and a global timed lockout.
//
// Handshake: _Data_In_Load is a level strobe. A command is accepted on the
// posedge where the strobe is 1 and was 0 on the previous posedge; _Request,
// _User and _Data_In are sampled on that same edge. Holding the strobe issues
// one command. Results are registered on the accepting edge. In LOCKED every
// rising edge is dropped.
module access_control_mu #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_USERS   = 4,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst,
   access_control_mu_if.slave  bus,
   output logic                dbg_locked
);
   localparam int USER_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
   localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
   localparam int CNT_W  = 3;

   localparam logic [2:0] ST_IDLE    = 3'b000;
   localparam logic [2:0] ST_STORED  = 3'b001;
   localparam logic [2:0] ST_GRANTED = 3'b010;
   localparam logic [2:0] ST_DENIED  = 3'b011;
   localparam logic [2:0] ST_LOCKED  = 3'b100;
   localparam logic [2:0] ST_NOT_ENR = 3'b101;
   localparam logic [2:0] ST_CLEARED = 3'b110;
   localparam logic [2:0] ST_LOGOUT  = 3'b111;

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t                state_q, state_d;
   logic                  load_q;
   logic [NUM_USERS-1:0]  enrolled_q, enrolled_d;
   logic [NUM_USERS-1:0]  granted_q, granted_d;
   logic [DATA_WIDTH-1:0] pw_q   [NUM_USERS];
   logic [DATA_WIDTH-1:0] pw_d   [NUM_USERS];
   logic [CNT_W-1:0]      fail_q [NUM_USERS];
   logic [CNT_W-1:0]      fail_d [NUM_USERS];
   logic [2:0]            status_q, status_d;
   logic [LOCK_W-1:0]     lock_q, lock_d;
   logic [USER_W-1:0]     lock_user_q, lock_user_d;
   logic [CNT_W-1:0]      next_fail;
   logic [USER_W-1:0]     u;
   logic                  accept;
   logic                  user_ok;

   assign u      = bus._User;
   assign accept = bus._Data_In_Load & ~load_q;

   // Slot indices past the last user only exist when NUM_USERS is not a power of two.
   if (NUM_USERS == (1 << USER_W)) begin : g_full_range
      assign user_ok = 1'b1;
   end else begin : g_partial_range
      assign user_ok = (u < USER_W'(NUM_USERS));
   end

   // Next-state and next-output computation for the IDLE/LOCKED controller.
   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      lock_d      = lock_q;
      lock_user_d = lock_user_q;
      enrolled_d  = enrolled_q;
      granted_d   = granted_q;
      pw_d        = pw_q;
      fail_d      = fail_q;
      next_fail   = '0;
      if (state_q == S_LOCKED) begin
         lock_d = lock_q - LOCK_W'(1);
         if (lock_q == LOCK_W'(1)) begin
            state_d             = S_IDLE;
            status_d            = ST_IDLE;
            fail_d[lock_user_q] = '0;
         end
      end else if (accept) begin
         if (!user_ok) begin
            status_d = ST_NOT_ENR;
         end else begin
            case (bus._Request)
               2'b00: begin
                  if (!enrolled_q[u]) begin
                     status_d = ST_NOT_ENR;
                  end else if (pw_q[u] == bus._Data_In) begin
                     status_d     = ST_GRANTED;
                     granted_d[u] = 1'b1;
                     fail_d[u]    = '0;
                  end else begin
                     granted_d[u] = 1'b0;
                     if (fail_q[u] < CNT_W'(MAX_TRIES)) begin
                        next_fail = fail_q[u] + CNT_W'(1);
                     end else begin
                        next_fail = fail_q[u];
                     end
                     fail_d[u] = next_fail;
                     if (next_fail == CNT_W'(MAX_TRIES)) begin
                        status_d    = ST_LOCKED;
                        state_d     = S_LOCKED;
                        lock_d      = LOCK_W'(LOCK_CYCLES);
                        lock_user_d = u;
                     end else begin
                        status_d = ST_DENIED;
                     end
                  end
               end
               2'b01: begin
                  if (!enrolled_q[u] || granted_q[u]) begin
                     status_d      = ST_STORED;
                     pw_d[u]       = bus._Data_In;
                     enrolled_d[u] = 1'b1;
                     fail_d[u]     = '0;
                  end else begin
                     status_d = ST_DENIED;
                  end
               end
               2'b10: begin
                  if (granted_q[u]) begin
                     status_d      = ST_CLEARED;
                     enrolled_d[u] = 1'b0;
                     pw_d[u]       = '0;
                     granted_d[u]  = 1'b0;
                     fail_d[u]     = '0;
                  end else begin
                     status_d = ST_DENIED;
                  end
               end
               default: begin
                  status_d     = ST_LOGOUT;
                  granted_d[u] = 1'b0;
               end
            endcase
         end
      end
   end

   // State register with synchronous active-low reset; the strobe history is kept even when locked.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         load_q      <= 1'b0;
         enrolled_q  <= '0;
         granted_q   <= '0;
         status_q    <= ST_IDLE;
         lock_q      <= '0;
         lock_user_q <= '0;
         for (int i = 0; i < NUM_USERS; i++) begin
            pw_q[i]   <= '0;
            fail_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         load_q      <= bus._Data_In_Load;
         enrolled_q  <= enrolled_d;
         granted_q   <= granted_d;
         status_q    <= status_d;
         lock_q      <= lock_d;
         lock_user_q <= lock_user_d;
         for (int i = 0; i < NUM_USERS; i++) begin
            pw_q[i]   <= pw_d[i];
            fail_q[i] <= fail_d[i];
         end
      end
   end

   assign bus._Status_Frame   = status_q;
   assign bus._Granted        = granted_q;
   assign bus._Lock_Remaining = lock_q;
   assign dbg_locked          = (state_q == S_LOCKED);
endmodule

// File: tb/tb_access_control_mu.sv
// Directed bench for access_control_mu: the driver pushes the expected
// {status, granted, lock remaining, locked} after each accepted strobe edge or
// probe cycle; the monitor pops and compares on the following negedge.
module tb_access_control_mu;
   localparam int W = 15;

   logic clk;
   logic rst;
   logic dbg_locked;
   logic probe;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks;
   int           failures;

   logic fire_q;
   logic probe_q;
   logic prev_load;

   access_control_mu_if #(.DATA_WIDTH(16), .NUM_USERS(4), .LOCK_CYCLES(64)) bus ();

   access_control_mu #(
      .DATA_WIDTH(16), .NUM_USERS(4), .MAX_TRIES(3), .LOCK_CYCLES(64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .dbg_locked (dbg_locked)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   // Monitor: note which posedges carried a strobe edge or a probe.
   always @(posedge clk) begin
      fire_q    <= bus._Data_In_Load && !prev_load;
      prev_load <= bus._Data_In_Load;
      probe_q   <= probe;
   end

   task automatic check_one();
      logic [W-1:0] act;
      logic [W-1:0] req;
      string        nm;
      act = {bus._Status_Frame, bus._Granted, bus._Lock_Remaining, dbg_locked};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_output: actual=%h required=<none queued>", act);
      end else begin
         req = exp_q.pop_front();
         nm  = name_q.pop_front();
         if (act !== req) begin
            failures++;
            $display("FAIL %s: actual st=%b gr=%b lk=%0d locked=%b required st=%b gr=%b lk=%0d locked=%b",
                     nm, act[14:12], act[11:8], act[7:1], act[0],
                     req[14:12], req[11:8], req[7:1], req[0]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (fire_q)  check_one();
      if (probe_q) check_one();
   end

   // Driver helpers.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] st, input logic [3:0] gr, input logic [6:0] lk,
                       input logic lkd, input string nm);
      exp_q.push_back({st, gr, lk, lkd});
      name_q.push_back(nm);
   endtask

   task automatic cmd(input logic [1:0] req, input logic [1:0] usr, input logic [15:0] data,
                      input int hold, input logic [2:0] st, input logic [3:0] gr,
                      input logic [6:0] lk, input logic lkd, input string nm);
      bus._Request      = req;
      bus._User         = usr;
      bus._Data_In      = data;
      bus._Data_In_Load = 1'b1;
      push(st, gr, lk, lkd, nm);
      repeat (hold) step();
      bus._Data_In_Load = 1'b0;
      step();
   endtask

   // Stimulus.
   initial begin
      logic pl;
      logic ld;
      logic [6:0] lk;
      checks            = 0;
      failures          = 0;
      fire_q            = 1'b0;
      probe_q           = 1'b0;
      prev_load         = 1'b0;
      probe             = 1'b0;
      rst               = 1'b0;
      bus._Request      = 2'b00;
      bus._User         = 2'd0;
      bus._Data_In      = 16'h0000;
      bus._Data_In_Load = 1'b0;
      step();
      step();
      probe = 1'b1;
      push(3'b000, 4'b0000, 7'd0, 1'b0, "reset_state");
      step();
      probe = 1'b0;
      rst   = 1'b1;
      step();

      // Enroll with held strobe, then authenticate / re-enroll / stale password.
      cmd(2'b01, 2'd0, 16'h1476, 2, 3'b001, 4'b0000, 7'd0, 1'b0, "enroll_u0_held");
      probe = 1'b1;
      push(3'b001, 4'b0000, 7'd0, 1'b0, "enroll_u0_hold_status");
      step();
      probe = 1'b0;
      cmd(2'b00, 2'd0, 16'h1476, 1, 3'b010, 4'b0001, 7'd0, 1'b0, "auth_u0_ok");
      cmd(2'b01, 2'd0, 16'h2456, 1, 3'b001, 4'b0001, 7'd0, 1'b0, "reenroll_u0_session");
      cmd(2'b00, 2'd0, 16'h1476, 1, 3'b011, 4'b0000, 7'd0, 1'b0, "auth_u0_stale");

      // Unenrolled slot, enroll without session, re-enroll refused.
      cmd(2'b00, 2'd1, 16'hAAAA, 1, 3'b101, 4'b0000, 7'd0, 1'b0, "auth_u1_unenrolled");
      cmd(2'b01, 2'd1, 16'hAAAA, 1, 3'b001, 4'b0000, 7'd0, 1'b0, "enroll_u1");
      cmd(2'b01, 2'd1, 16'h0000, 1, 3'b011, 4'b0000, 7'd0, 1'b0, "reenroll_u1_nosession");
      cmd(2'b00, 2'd1, 16'hAAAA, 1, 3'b010, 4'b0010, 7'd0, 1'b0, "auth_u1_ok");
      cmd(2'b11, 2'd1, 16'h0000, 1, 3'b111, 4'b0000, 7'd0, 1'b0, "logout_u1");

      // User 3 session, then lock out on user 2.
      cmd(2'b01, 2'd3, 16'h5555, 1, 3'b001, 4'b0000, 7'd0, 1'b0, "enroll_u3");
      cmd(2'b00, 2'd3, 16'h5555, 1, 3'b010, 4'b1000, 7'd0, 1'b0, "auth_u3_ok");
      cmd(2'b01, 2'd2, 16'h1234, 1, 3'b001, 4'b1000, 7'd0, 1'b0, "enroll_u2");
      cmd(2'b00, 2'd2, 16'h1111, 1, 3'b011, 4'b1000, 7'd0, 1'b0, "auth_u2_bad1");
      cmd(2'b00, 2'd2, 16'h2222, 1, 3'b011, 4'b1000, 7'd0, 1'b0, "auth_u2_bad2");
      cmd(2'b00, 2'd2, 16'h0000, 1, 3'b100, 4'b1000, 7'd64, 1'b1, "auth_u2_bad3_lock");

      // Countdown: 63 passed inside cmd, so the next posedge shows 62.
      pl = 1'b0;
      for (int c = 0; c < 66; c++) begin
         ld = (c == 5) || (c >= 58);
         if (c == 5) begin
            bus._Request = 2'b11;
            bus._User    = 2'd3;
         end else if (c == 58) begin
            bus._Request = 2'b00;
            bus._User    = 2'd2;
            bus._Data_In = 16'h1234;
         end
         bus._Data_In_Load = ld;
         lk = (c < 62) ? 7'(62 - c) : 7'd0;
         push((c < 62) ? 3'b100 : 3'b000, 4'b1000, lk, (c < 62), "lock_tick");
         if (ld && !pl) push(3'b100, 4'b1000, lk, 1'b1, "lock_strobe_ignored");
         pl    = ld;
         probe = 1'b1;
         step();
      end
      probe             = 1'b0;
      bus._Data_In_Load = 1'b0;
      step();

      cmd(2'b00, 2'd2, 16'h1234, 1, 3'b010, 4'b1100, 7'd0, 1'b0, "auth_u2_after_unlock");
      cmd(2'b11, 2'd3, 16'h0000, 1, 3'b111, 4'b0100, 7'd0, 1'b0, "logout_u3");
      cmd(2'b11, 2'd2, 16'h0000, 1, 3'b111, 4'b0000, 7'd0, 1'b0, "logout_u2");

      // Clear slot rules and password zero.
      cmd(2'b10, 2'd1, 16'h0000, 1, 3'b011, 4'b0000, 7'd0, 1'b0, "clear_u1_nosession");
      cmd(2'b00, 2'd0, 16'h2456, 1, 3'b010, 4'b0001, 7'd0, 1'b0, "auth_u0_new_pw");
      cmd(2'b10, 2'd0, 16'h0000, 1, 3'b110, 4'b0000, 7'd0, 1'b0, "clear_u0");
      cmd(2'b00, 2'd0, 16'h2456, 1, 3'b101, 4'b0000, 7'd0, 1'b0, "auth_u0_cleared");
      cmd(2'b01, 2'd0, 16'h0000, 1, 3'b001, 4'b0000, 7'd0, 1'b0, "enroll_u0_zero");
      cmd(2'b00, 2'd0, 16'h0000, 1, 3'b010, 4'b0001, 7'd0, 1'b0, "auth_u0_zero");

      // Second lockout, aborted by reset at 30 cycles remaining.
      cmd(2'b00, 2'd2, 16'h0001, 1, 3'b011, 4'b0001, 7'd0, 1'b0, "auth_u2_bad1b");
      cmd(2'b00, 2'd2, 16'h0002, 1, 3'b011, 4'b0001, 7'd0, 1'b0, "auth_u2_bad2b");
      cmd(2'b00, 2'd2, 16'h0003, 1, 3'b100, 4'b0001, 7'd64, 1'b1, "auth_u2_bad3b_lock");
      for (int c = 0; c < 33; c++) begin
         probe = (c == 32);
         if (c == 32) push(3'b100, 4'b0001, 7'd30, 1'b1, "lock_at_30");
         step();
      end
      rst   = 1'b0;
      probe = 1'b1;
      push(3'b000, 4'b0000, 7'd0, 1'b0, "reset_mid_lock");
      step();
      probe = 1'b0;
      rst   = 1'b1;
      step();
      cmd(2'b00, 2'd0, 16'h1476, 1, 3'b101, 4'b0000, 7'd0, 1'b0, "auth_u0_after_reset");

      step();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expectations: actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
